// File: rtl/product_bcd_conv.sv
// Converts the signed multiplier product to sign + packed BCD, one double-dabble shift per clock.
// Optional build macro LEADING_ZERO_BLANK_EN: digits above the leading nonzero digit become 4'hF.
module product_bcd_conv #(
  parameter int W_product = 22,
  parameter int N_digits  = 7
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    done_in,
  input  logic [W_product-1:0]    product,
  output logic                    busy,
  output logic                    valid,
  output logic                    sign,
  output logic [4*N_digits-1:0]   bcd
);

  localparam int CNT_W = $clog2(W_product);
  localparam int BCD_W = 4 * N_digits;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_CONV = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 done_dly_q, done_dly_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 sign_q, sign_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [W_product-1:0] mag_q, mag_d;
  logic                 sgn_q, sgn_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 start;
  logic [BCD_W-1:0]     adj_scratch;
  logic [BCD_W-1:0]     shifted_scratch;
  logic [BCD_W-1:0]     final_bcd;

  assign start = done_in & ~done_dly_q;

  // Digit correction before the shift keeps each digit within 0..9 after doubling.
  always_comb begin
    adj_scratch = scratch_q;
    for (int i = 0; i < N_digits; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_scratch[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted_scratch = {adj_scratch[BCD_W-2:0], mag_q[W_product-1]};
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen_nonzero;
    final_bcd    = shifted_scratch;
    seen_nonzero = 1'b0;
    for (int i = N_digits - 1; i >= 1; i--) begin
      if (shifted_scratch[4*i +: 4] != 4'd0) begin
        seen_nonzero = 1'b1;
      end
      if (!seen_nonzero) begin
        final_bcd[4*i +: 4] = 4'hF;
      end
    end
  end
`else
  assign final_bcd = shifted_scratch;
`endif

  always_comb begin
    state_d    = state_q;
    done_dly_d = done_in;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    mag_d      = mag_q;
    sgn_d      = sgn_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          busy_d  = 1'b1;
        end
      end
      S_ARM: begin
        // Two's-complement negation; the most negative value maps to its own bit pattern,
        // which read as unsigned is exactly its magnitude.
        mag_d     = product[W_product-1] ? (~product + W_product'(1)) : product;
        sgn_d     = product[W_product-1];
        scratch_d = '0;
        cnt_d     = CNT_W'(W_product - 1);
        state_d   = S_CONV;
      end
      S_CONV: begin
        scratch_d = shifted_scratch;
        mag_d     = {mag_q[W_product-2:0], 1'b0};
        if (cnt_q == '0) begin
          bcd_d   = final_bcd;
          sign_d  = sgn_q;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      done_dly_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      mag_q      <= '0;
      sgn_q      <= 1'b0;
      scratch_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      done_dly_q <= done_dly_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      sign_q     <= sign_d;
      bcd_q      <= bcd_d;
      mag_q      <= mag_d;
      sgn_q      <= sgn_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign sign  = sign_q;
  assign bcd   = bcd_q;

endmodule
